mem_copy_master: RTL and testbench
==================================

MEM_COPY_MASTER -- requirements
Module: mem_copy_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the maximum cycles to wait for mem_ready per transfer (1..65535).
REQ-002 SHALL have port clk  input  1  the only clock, rising-edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  one-cycle copy request.
REQ-005 SHALL have port src_addr  input  32  source byte address, sampled on accepted start.
REQ-006 SHALL have port dst_addr  input  32  destination byte address, sampled on accepted start.
REQ-007 SHALL have port len  input  16  word count, sampled on accepted start.
REQ-008 SHALL have port busy  output  1  copy in progress.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port error  output  1  timeout flag, held until the next accepted start or reset.
REQ-011 SHALL have port mem_valid  output  1  bus request to the memory responder.
REQ-012 SHALL have port mem_wstrb  output  4  byte-write strobes; 0000 = read.
REQ-013 SHALL have port mem_addr  output  32  word-aligned bus address.
REQ-014 SHALL have port mem_wdata  output  32  write data.
REQ-015 SHALL have port mem_ready  input  1  responder completion, registered one cycle after the responder sees mem_valid.
REQ-016 SHALL have port mem_rdata  input  32  read data, valid while mem_ready is high.

Function
REQ-017 States: IDLE, RD_REQ, RD_GAP, WR_REQ, WR_GAP, FINISH; all outputs registered.
REQ-018 IDLE: start=1 is accepted; src/dst are latched with bits [1:0] forced to 0, len is latched, error is cleared, and the next state is RD_REQ (len!=0) or FINISH (len==0).
REQ-019 start while not IDLE SHALL be ignored, with no effect on the running copy.
REQ-020 RD_REQ: mem_valid=1, mem_wstrb=0000, mem_addr=current src; on mem_ready=1, mem_rdata is captured into an internal data register and the next state is RD_GAP.
REQ-021 WR_REQ: mem_valid=1, mem_wstrb=1111, mem_addr=current dst, mem_wdata=captured word; on mem_ready=1 the next state is WR_GAP.
REQ-022 mem_addr/mem_wstrb/mem_wdata SHALL remain stable while mem_valid=1 and mem_ready=0.
REQ-023 GAP states: mem_valid=0 for exactly one cycle, because the responder's ready is its registered select and stays high one cycle after a transfer; mem_ready SHALL be ignored whenever mem_valid=0.
REQ-024 RD_GAP SHALL go to WR_REQ.
REQ-025 WR_GAP: src+=4, dst+=4, remaining count-=1; next state is RD_REQ if remaining!=0, else FINISH.
REQ-026 Address increment SHALL wrap modulo 2^32 (0xFFFFFFFC+4 -> 0x00000000) with no error.
REQ-027 FINISH: done=1 for one cycle, busy=0 on the following cycle, and the next state is IDLE.
REQ-028 busy=1 from the cycle after an accepted start through the FINISH cycle inclusive.
REQ-029 Timeout: a per-request counter clears on entry to RD_REQ/WR_REQ and increments each cycle with mem_ready=0.
REQ-030 On reaching TIMEOUT, the block SHALL set error=1, drop mem_valid next cycle, and go to FINISH; done still pulses, and remaining words are not copied.
REQ-031 mem_ready arriving in the same cycle the counter reaches TIMEOUT SHALL count as success, with no error.
REQ-032 Throughput with a 1-cycle-registered-ready responder: 6 cycles per word (read 2, gap 1, write 2, gap 1).

Reset
REQ-033 reset=1 at any edge, including mid-transfer, SHALL produce on the next cycle: state=IDLE, busy=0, done=0, error=0, mem_valid=0, mem_wstrb=0000, mem_addr=0, mem_wdata=0, counters=0.
REQ-034 After reset deasserts, the first start SHALL be accepted normally, and no bus request SHALL be issued before it.

Verification
REQ-035 Bench: src=0x100, dst=0x200, len=3, words 0xA1,0xB2,0xC3 -> dst 0x200/0x204/0x208 hold those words, done pulses once, 18 busy transfer cycles, error=0.
REQ-036 Bench: len=0 -> done pulses the cycle after start, mem_valid never asserted.
REQ-037 Bench: responder stalls mem_ready for 5 cycles on a write -> address/data/strobes stable throughout, copy completes correctly.
REQ-038 Bench: TIMEOUT=8, responder never answers -> mem_valid drops after 8 wait cycles, error=1, done pulses, state IDLE.
REQ-039 Bench: src=0xFFFFFFFC, len=2 -> second read at 0x00000000; also src=0x103 -> first read at 0x100.
REQ-040 Bench: reset asserted during WR_REQ, then start raised while busy on a fresh copy -> mem_valid=0 next cycle after reset, and the second start is ignored with no change to the count.

Source files
------------

// File: rtl/mem_copy_master.sv
// Word-by-word memory copy master: reads a word from the source, writes it
// to the destination, and repeats for the requested count. Every bus request
// has a cycle budget of TIMEOUT cycles. All outputs are registered.
module mem_copy_master #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] src_addr,
    input  logic [31:0] dst_addr,
    input  logic [15:0] len,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        mem_valid,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_GAP,
        WR_REQ,
        WR_GAP,
        FINISH
    } state_t;

    // Wait count at which a request without mem_ready is abandoned.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:0] src_q, src_d;
    logic [31:0] dst_q, dst_d;
    logic [15:0] rem_q, rem_d;
    logic [31:0] data_q, data_d;
    logic [15:0] cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic        valid_q, valid_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    logic        wait_expired;
    logic [31:0] src_aligned;
    logic [31:0] dst_aligned;

    // Byte offsets of the start addresses are dropped; the bus is word-only.
    logic        unused_addr_lsbs;
    assign unused_addr_lsbs = ^{src_addr[1:0], dst_addr[1:0]};

    assign src_aligned  = {src_addr[31:2], 2'b00};
    assign dst_aligned  = {dst_addr[31:2], 2'b00};
    assign wait_expired = (cnt_q == TMO_LAST);

    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign mem_valid = valid_q;
    assign mem_wstrb = wstrb_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    // State and registered outputs; synchronous reset clears everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            valid_q <= 1'b0;
            wstrb_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
            valid_q <= valid_d;
            wstrb_q <= wstrb_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Next state plus the output values for the state being entered, so the
    // bus signals are registered yet line up with the state register.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        error_d = error_q;
        valid_d = valid_q;
        wstrb_d = wstrb_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        unique case (state_q)
            IDLE: begin
                busy_d  = 1'b0;
                valid_d = 1'b0;
                if (start) begin
                    src_d   = src_aligned;
                    dst_d   = dst_aligned;
                    rem_d   = len;
                    error_d = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    if (len != 16'd0) begin
                        state_d = RD_REQ;
                        valid_d = 1'b1;
                        wstrb_d = 4'b0000;
                        addr_d  = src_aligned;
                    end else begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                    end
                end
            end

            RD_REQ: begin
                // A ready in the expiring cycle still completes the read.
                if (mem_ready) begin
                    data_d  = mem_rdata;
                    state_d = RD_GAP;
                    valid_d = 1'b0;
                end else if (wait_expired) begin
                    error_d = 1'b1;
                    valid_d = 1'b0;
                    state_d = FINISH;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            RD_GAP: begin
                state_d = WR_REQ;
                valid_d = 1'b1;
                wstrb_d = 4'b1111;
                addr_d  = dst_q;
                wdata_d = data_q;
                cnt_d   = '0;
            end

            WR_REQ: begin
                if (mem_ready) begin
                    state_d = WR_GAP;
                    valid_d = 1'b0;
                end else if (wait_expired) begin
                    error_d = 1'b1;
                    valid_d = 1'b0;
                    state_d = FINISH;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            WR_GAP: begin
                src_d   = src_q + 32'd4;
                dst_d   = dst_q + 32'd4;
                rem_d   = rem_q - 16'd1;
                wstrb_d = 4'b0000;
                if (rem_q != 16'd1) begin
                    state_d = RD_REQ;
                    valid_d = 1'b1;
                    addr_d  = src_q + 32'd4;
                    cnt_d   = '0;
                end else begin
                    state_d = FINISH;
                    done_d  = 1'b1;
                end
            end

            FINISH: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_copy_master.sv
// Directed bench for mem_copy_master with a registered-ready memory responder.
module tb_mem_copy_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] len;
    logic        busy;
    logic        done;
    logic        error;
    logic        mem_valid;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    mem_copy_master #(.TIMEOUT(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .mem_valid (mem_valid),
        .mem_wstrb (mem_wstrb),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    initial forever #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Responder configuration
    logic silent   = 1'b0;
    int   stall_wr = 0;
    int   stall_rd = 0;

    // Responder state and transfer logs
    logic        rdy   = 1'b0;
    logic [31:0] rdata = '0;
    int          waited = 0;
    logic [31:0] wr_addr [64];
    logic [31:0] wr_data [64];
    logic [31:0] rd_addr [64];
    int          wr_n = 0;
    int          rd_n = 0;

    // Monitor counters
    int busy_cnt   = 0;
    int done_cnt   = 0;
    int valid_cnt  = 0;
    int wvalid_cnt = 0;
    int rvalid_cnt = 0;
    int stab_viol  = 0;
    logic        p_valid = 1'b0;
    logic        p_ready = 1'b0;
    logic [3:0]  p_wstrb = '0;
    logic [31:0] p_addr  = '0;
    logic [31:0] p_wdata = '0;

    assign mem_ready = rdy;
    assign mem_rdata = rdata;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'h0000_00A1;
            32'h0000_0104: return 32'h0000_00B2;
            32'h0000_0108: return 32'h0000_00C3;
            default:       return a ^ 32'hDEAD_0000;
        endcase
    endfunction

    // Responder: ready is its registered select, after an optional stall.
    always @(posedge clk) begin
        if (reset) begin
            rdy    <= 1'b0;
            waited <= 0;
        end else if (mem_valid && !rdy) begin
            if (!silent && waited >= ((mem_wstrb != 4'h0) ? stall_wr : stall_rd)) begin
                rdy    <= 1'b1;
                rdata  <= word_at(mem_addr);
                waited <= 0;
            end else begin
                waited <= waited + 1;
            end
        end else if (mem_valid && rdy) begin
            if (mem_wstrb != 4'h0) begin
                if (wr_n < 64) begin
                    wr_addr[wr_n] <= mem_addr;
                    wr_data[wr_n] <= mem_wdata;
                end
                wr_n <= wr_n + 1;
            end else begin
                if (rd_n < 64) rd_addr[rd_n] <= mem_addr;
                rd_n <= rd_n + 1;
            end
            rdy <= 1'b1;
        end else begin
            rdy    <= 1'b0;
            waited <= 0;
        end
    end

    // Cycle counters and bus-stability watcher, sampled mid-cycle.
    always @(negedge clk) begin
        busy_cnt   <= busy_cnt + (busy ? 1 : 0);
        done_cnt   <= done_cnt + (done ? 1 : 0);
        valid_cnt  <= valid_cnt + (mem_valid ? 1 : 0);
        wvalid_cnt <= wvalid_cnt + ((mem_valid && mem_wstrb == 4'hF) ? 1 : 0);
        rvalid_cnt <= rvalid_cnt + ((mem_valid && mem_wstrb == 4'h0) ? 1 : 0);
        if (p_valid && !p_ready && mem_valid &&
            (mem_addr != p_addr || mem_wstrb != p_wstrb || mem_wdata != p_wdata))
            stab_viol <= stab_viol + 1;
        p_valid <= mem_valid;
        p_ready <= mem_ready;
        p_addr  <= mem_addr;
        p_wstrb <= mem_wstrb;
        p_wdata <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic pulse_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
        @(negedge clk);
        src_addr = s;
        dst_addr = d;
        len      = n;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 300 && done !== 1'b1; i++) @(negedge clk);
        chk(tag, 32'(done), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        int b0, d0, w0, r0, v0, wv0, rv0, s0;
        reset    = 1'b1;
        start    = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        len      = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_done",  32'(done),      32'd0);
        chk("rst_error", 32'(error),     32'd0);
        chk("rst_valid", 32'(mem_valid), 32'd0);
        chk("rst_wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst_addr",  mem_addr,       32'd0);
        chk("rst_wdata", mem_wdata,      32'd0);
        reset = 1'b0;
        @(negedge clk);
        v0 = valid_cnt;
        repeat (3) @(negedge clk);
        chk("idle_no_request", 32'(valid_cnt - v0), 32'd0);

        // Three-word copy
        b0 = busy_cnt; d0 = done_cnt; w0 = wr_n; r0 = rd_n;
        pulse_start(32'h100, 32'h200, 16'd3);
        wait_done("cp3_done_seen");
        chk("cp3_writes", 32'(wr_n - w0), 32'd3);
        chk("cp3_wa0", wr_addr[w0],   32'h200);
        chk("cp3_wd0", wr_data[w0],   32'hA1);
        chk("cp3_wa1", wr_addr[w0+1], 32'h204);
        chk("cp3_wd1", wr_data[w0+1], 32'hB2);
        chk("cp3_wa2", wr_addr[w0+2], 32'h208);
        chk("cp3_wd2", wr_data[w0+2], 32'hC3);
        chk("cp3_ra2", rd_addr[r0+2], 32'h108);
        chk("cp3_done_once",  32'(done_cnt - d0), 32'd1);
        chk("cp3_busy_cycles", 32'(busy_cnt - b0), 32'd19);
        chk("cp3_error", 32'(error), 32'd0);
        chk("cp3_busy_after", 32'(busy), 32'd0);

        // Zero-length copy
        v0 = valid_cnt; d0 = done_cnt; w0 = wr_n;
        pulse_start(32'h300, 32'h310, 16'd0);
        chk("len0_done_next", 32'(done), 32'd1);
        chk("len0_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("len0_done_drop", 32'(done), 32'd0);
        chk("len0_busy_drop", 32'(busy), 32'd0);
        @(negedge clk);
        chk("len0_no_valid", 32'(valid_cnt - v0), 32'd0);
        chk("len0_done_once", 32'(done_cnt - d0), 32'd1);
        chk("len0_no_write", 32'(wr_n - w0), 32'd0);

        // Write stalled for 5 extra cycles
        stall_wr = 5;
        w0 = wr_n; wv0 = wvalid_cnt; s0 = stab_viol;
        pulse_start(32'h400, 32'h500, 16'd1);
        wait_done("stall_done_seen");
        stall_wr = 0;
        chk("stall_wr_cycles", 32'(wvalid_cnt - wv0), 32'd7);
        chk("stall_stable", 32'(stab_viol - s0), 32'd0);
        chk("stall_writes", 32'(wr_n - w0), 32'd1);
        chk("stall_wa", wr_addr[w0], 32'h500);
        chk("stall_wd", wr_data[w0], 32'hDEAD_0400);
        chk("stall_error", 32'(error), 32'd0);

        // Ready arrives exactly as the wait count reaches TIMEOUT
        stall_rd = 6;
        w0 = wr_n; rv0 = rvalid_cnt;
        pulse_start(32'h600, 32'h700, 16'd1);
        wait_done("edge_done_seen");
        stall_rd = 0;
        chk("edge_rd_cycles", 32'(rvalid_cnt - rv0), 32'd8);
        chk("edge_error", 32'(error), 32'd0);
        chk("edge_wd", wr_data[w0], 32'hDEAD_0600);

        // Responder never answers
        silent = 1'b1;
        v0 = valid_cnt; d0 = done_cnt; w0 = wr_n;
        pulse_start(32'h800, 32'h900, 16'd2);
        wait_done("tmo_done_seen");
        silent = 1'b0;
        chk("tmo_valid_cycles", 32'(valid_cnt - v0), 32'd8);
        chk("tmo_error", 32'(error), 32'd1);
        chk("tmo_done_once", 32'(done_cnt - d0), 32'd1);
        chk("tmo_no_write", 32'(wr_n - w0), 32'd0);
        chk("tmo_idle_busy", 32'(busy), 32'd0);
        chk("tmo_idle_valid", 32'(mem_valid), 32'd0);
        repeat (2) @(negedge clk);
        chk("tmo_error_held", 32'(error), 32'd1);

        // Address wrap at the top of memory
        r0 = rd_n; w0 = wr_n;
        pulse_start(32'hFFFF_FFFC, 32'h1000, 16'd2);
        chk("wrap_error_cleared", 32'(error), 32'd0);
        wait_done("wrap_done_seen");
        chk("wrap_ra0", rd_addr[r0],   32'hFFFF_FFFC);
        chk("wrap_ra1", rd_addr[r0+1], 32'h0000_0000);
        chk("wrap_wd1", wr_data[w0+1], 32'hDEAD_0000);
        chk("wrap_wa1", wr_addr[w0+1], 32'h1004);
        chk("wrap_error", 32'(error), 32'd0);

        // Unaligned start address
        r0 = rd_n; w0 = wr_n;
        pulse_start(32'h103, 32'h1103, 16'd1);
        wait_done("unal_done_seen");
        chk("unal_ra", rd_addr[r0], 32'h100);
        chk("unal_wa", wr_addr[w0], 32'h1100);
        chk("unal_wd", wr_data[w0], 32'hA1);

        // Reset in the middle of a write request
        pulse_start(32'h2000, 32'h3000, 16'd4);
        for (int i = 0; i < 50 && !(mem_valid && mem_wstrb == 4'hF); i++) @(negedge clk);
        chk("mid_wr_reached", {27'd0, mem_valid, mem_wstrb}, 32'h1F);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", 32'(mem_valid), 32'd0);
        chk("mid_rst_busy",  32'(busy),      32'd0);
        chk("mid_rst_addr",  mem_addr,       32'd0);
        reset = 1'b0;
        @(negedge clk);
        v0 = valid_cnt;
        repeat (2) @(negedge clk);
        chk("mid_no_request", 32'(valid_cnt - v0), 32'd0);

        // Fresh copy with a start pulse while busy that must be ignored
        b0 = busy_cnt; d0 = done_cnt; w0 = wr_n;
        pulse_start(32'h4000, 32'h5000, 16'd2);
        repeat (3) @(negedge clk);
        src_addr = 32'h6000;
        dst_addr = 32'h7000;
        len      = 16'd5;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        wait_done("ign_done_seen");
        chk("ign_writes", 32'(wr_n - w0), 32'd2);
        chk("ign_wa0", wr_addr[w0],   32'h5000);
        chk("ign_wd0", wr_data[w0],   32'hDEAD_4000);
        chk("ign_wa1", wr_addr[w0+1], 32'h5004);
        chk("ign_busy_cycles", 32'(busy_cnt - b0), 32'd13);
        chk("ign_done_once", 32'(done_cnt - d0), 32'd1);
        repeat (3) @(negedge clk);
        chk("ign_stays_idle", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
